// File: rtl/pc_fetch_stage_pkg.sv
// Shared types for the PC fetch stage: FSM encoding, machine word type and
// default halt/reset constants.
package pc_fetch_stage_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    localparam word_t DEFAULT_HALT_INSTR = 32'hFFFF_FFFF;
    localparam word_t DEFAULT_RESET_PC   = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_stage_ifid_latch.sv
// IF/ID pipeline latch: instruction word, its next-PC and a valid flag,
// with load, hold and bubble controls (bubble wins over load).
module ifid_latch
    import pc_fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_bubble,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_npc,
    output logic [31:0] o_instr,
    output logic [31:0] o_npc,
    output logic        o_valid
);

    word_t r_instr;
    word_t r_npc;
    logic  r_valid;

    // A bubble keeps the old instruction/npc and only clears valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr <= 32'h0000_0000;
            r_npc   <= 32'h0000_0000;
            r_valid <= 1'b0;
        end else if (i_bubble) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_instr <= i_instr;
            r_npc   <= i_npc;
            r_valid <= 1'b1;
        end else begin
            r_valid <= r_valid;
        end
    end

    assign o_instr = r_instr;
    assign o_npc   = r_npc;
    assign o_valid = r_valid;

endmodule

// File: rtl/pc_fetch_stage.sv
// Fetch stage: PC register, BOOT/RUN/HALT control FSM and IF/ID latch.
// Define FETCH_PERF_CNT_EN to build the fetch/stall performance counters.
module pc_fetch_stage
    import pc_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter logic [31:0] HALT_INSTR = DEFAULT_HALT_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] pc_out,
    input  logic [31:0] pc_incr,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_npc,
    output logic        ifid_valid,
    output logic        halted,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;
    word_t        r_pc;
    word_t        w_pc_nxt;
    logic         r_halted;
    logic         w_load;
    logic         w_bubble;

    // State, PC and halted flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_BOOT;
            r_pc     <= RESET_PC;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_halted <= (w_state_nxt == ST_HALT);
        end
    end

    // Next-state/next-PC: redirect beats stall beats halt detect beats fetch.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_load      = 1'b0;
        w_bubble    = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (br_taken) begin
                    w_pc_nxt = br_target;
                    w_bubble = 1'b1;
                end else if (stall) begin
                    w_pc_nxt = r_pc;
                end else if (imem_data == HALT_INSTR) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_HALT;
                end else begin
                    w_pc_nxt = pc_incr;
                    w_load   = 1'b1;
                end
            end
            ST_HALT: begin
                if (br_taken) begin
                    w_pc_nxt    = br_target;
                    w_bubble    = 1'b1;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_bubble = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_BOOT;
                w_pc_nxt    = RESET_PC;
            end
        endcase
    end

    ifid_latch u_ifid_latch (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_bubble (w_bubble),
        .i_instr  (imem_data),
        .i_npc    (pc_incr),
        .o_instr  (ifid_instr),
        .o_npc    (ifid_npc),
        .o_valid  (ifid_valid)
    );

`ifdef FETCH_PERF_CNT_EN
    word_t r_fetch_cnt;
    word_t r_stall_cnt;
    logic  w_stall_cnt_en;

    assign w_stall_cnt_en = (r_state == ST_RUN) && stall && !br_taken;

    // Free-running wrap-around performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_cnt <= 32'h0000_0000;
            r_stall_cnt <= 32'h0000_0000;
        end else begin
            r_fetch_cnt <= w_load ? (r_fetch_cnt + 32'd1) : r_fetch_cnt;
            r_stall_cnt <= w_stall_cnt_en ? (r_stall_cnt + 32'd1) : r_stall_cnt;
        end
    end

    assign fetch_cnt = r_fetch_cnt;
    assign stall_cnt = r_stall_cnt;
`else
    assign fetch_cnt = 32'h0000_0000;
    assign stall_cnt = 32'h0000_0000;
`endif

    assign pc_out    = r_pc;
    assign imem_addr = r_pc;
    assign halted    = r_halted;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed self-checking bench for pc_fetch_stage; memory returns addr+0x100
// unless a halt word is planted at halt_addr.
module tb_pc_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] pc_out;
    logic [31:0] pc_incr;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_npc;
    logic        ifid_valid;
    logic        halted;
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;

    logic        halt_en;
    logic [31:0] halt_addr;
    int          checks;
    int          errors;

`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    pc_fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .pc_out     (pc_out),
        .pc_incr    (pc_incr),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .ifid_instr (ifid_instr),
        .ifid_npc   (ifid_npc),
        .ifid_valid (ifid_valid),
        .halted     (halted),
        .fetch_cnt  (fetch_cnt),
        .stall_cnt  (stall_cnt)
    );

    assign pc_incr   = pc_out + 32'd1;
    assign imem_data = (halt_en && (imem_addr == halt_addr)) ? 32'hFFFF_FFFF : (imem_addr + 32'h0000_0100);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (pc_out !== 32'd0) begin errors++; $display("FAIL rst_pc: got %h exp %h", pc_out, 32'd0); end
        checks++; if (ifid_valid !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL rst_flags: got valid=%b halted=%b exp 0 0", ifid_valid, halted); end
        checks++; if (ifid_instr !== 32'd0 || ifid_npc !== 32'd0) begin errors++; $display("FAIL rst_ifid: got %h/%h exp 0/0", ifid_instr, ifid_npc); end
        checks++; if (fetch_cnt !== 32'd0 || stall_cnt !== 32'd0) begin errors++; $display("FAIL rst_cnt: got %h/%h exp 0/0", fetch_cnt, stall_cnt); end
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        checks++; if (pc_out !== 32'd0 || ifid_valid !== 1'b0) begin errors++; $display("FAIL boot: got pc=%h valid=%b exp 0 0", pc_out, ifid_valid); end
    endtask

    task automatic test_sequential();
        tick();
        checks++; if (pc_out !== 32'd1 || ifid_instr !== 32'h100 || ifid_npc !== 32'd1 || ifid_valid !== 1'b1) begin errors++; $display("FAIL seq1: got pc=%h instr=%h npc=%h v=%b exp 1 100 1 1", pc_out, ifid_instr, ifid_npc, ifid_valid); end
        tick();
        checks++; if (pc_out !== 32'd2 || ifid_instr !== 32'h101 || ifid_npc !== 32'd2) begin errors++; $display("FAIL seq2: got pc=%h instr=%h npc=%h exp 2 101 2", pc_out, ifid_instr, ifid_npc); end
        tick();
        checks++; if (pc_out !== 32'd3 || imem_addr !== 32'd3) begin errors++; $display("FAIL seq3: got pc=%h addr=%h exp 3 3", pc_out, imem_addr); end
    endtask

    task automatic test_stall();
        tick();
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (pc_out !== 32'd5 || ifid_instr !== 32'h104 || ifid_npc !== 32'd5 || ifid_valid !== 1'b1) begin errors++; $display("FAIL stall_hold%0d: got pc=%h instr=%h npc=%h v=%b exp 5 104 5 1", i, pc_out, ifid_instr, ifid_npc, ifid_valid); end
        end
        stall = 1'b0;
        checks++; if (stall_cnt !== (PERF ? 32'd3 : 32'd0)) begin errors++; $display("FAIL stall_cnt: got %0d exp %0d", stall_cnt, PERF ? 3 : 0); end
        checks++; if (fetch_cnt !== (PERF ? 32'd5 : 32'd0)) begin errors++; $display("FAIL fetch_cnt: got %0d exp %0d", fetch_cnt, PERF ? 5 : 0); end
    endtask

    task automatic test_branch_during_stall();
        tick();
        tick();
        checks++; if (pc_out !== 32'd7) begin errors++; $display("FAIL br_pre: got %h exp 7", pc_out); end
        stall = 1'b1; br_taken = 1'b1; br_target = 32'h40;
        tick();
        stall = 1'b0; br_taken = 1'b0;
        checks++; if (pc_out !== 32'h40 || ifid_valid !== 1'b0 || ifid_instr !== 32'h106 || ifid_npc !== 32'd7) begin errors++; $display("FAIL br_redirect: got pc=%h v=%b instr=%h npc=%h exp 40 0 106 7", pc_out, ifid_valid, ifid_instr, ifid_npc); end
        tick();
        checks++; if (pc_out !== 32'h41 || ifid_npc !== 32'h41 || ifid_instr !== 32'h140 || ifid_valid !== 1'b1) begin errors++; $display("FAIL br_after: got pc=%h npc=%h instr=%h v=%b exp 41 41 140 1", pc_out, ifid_npc, ifid_instr, ifid_valid); end
        checks++; if (stall_cnt !== (PERF ? 32'd3 : 32'd0)) begin errors++; $display("FAIL br_stall_cnt: got %0d exp %0d", stall_cnt, PERF ? 3 : 0); end
    endtask

    task automatic test_halt();
        br_taken = 1'b1; br_target = 32'd9;
        tick();
        br_taken = 1'b0;
        halt_en = 1'b1; halt_addr = 32'd9;
        tick();
        checks++; if (halted !== 1'b1 || pc_out !== 32'd9 || ifid_instr !== 32'hFFFF_FFFF || ifid_npc !== 32'd10 || ifid_valid !== 1'b1) begin errors++; $display("FAIL halt_enter: got h=%b pc=%h instr=%h npc=%h v=%b exp 1 9 ffffffff a 1", halted, pc_out, ifid_instr, ifid_npc, ifid_valid); end
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (halted !== 1'b1 || pc_out !== 32'd9 || ifid_valid !== 1'b0 || ifid_instr !== 32'hFFFF_FFFF) begin errors++; $display("FAIL halt_hold%0d: got h=%b pc=%h v=%b instr=%h exp 1 9 0 ffffffff", i, halted, pc_out, ifid_valid, ifid_instr); end
        end
        stall = 1'b0; br_taken = 1'b1; br_target = 32'h20;
        tick();
        br_taken = 1'b0; halt_en = 1'b0;
        checks++; if (halted !== 1'b0 || pc_out !== 32'h20 || ifid_valid !== 1'b0) begin errors++; $display("FAIL halt_exit: got h=%b pc=%h v=%b exp 0 20 0", halted, pc_out, ifid_valid); end
        tick();
        checks++; if (pc_out !== 32'h21 || ifid_instr !== 32'h120 || ifid_valid !== 1'b1) begin errors++; $display("FAIL halt_resume: got pc=%h instr=%h v=%b exp 21 120 1", pc_out, ifid_instr, ifid_valid); end
    endtask

    task automatic test_wrap();
        br_taken = 1'b1; br_target = 32'hFFFF_FFFF;
        tick();
        br_taken = 1'b0;
        checks++; if (pc_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_pc0: got %h exp ffffffff", pc_out); end
        tick();
        checks++; if (pc_out !== 32'd0 || ifid_npc !== 32'd0 || ifid_instr !== 32'h0000_00FF || ifid_valid !== 1'b1) begin errors++; $display("FAIL wrap_pc1: got pc=%h npc=%h instr=%h v=%b exp 0 0 ff 1", pc_out, ifid_npc, ifid_instr, ifid_valid); end
        tick();
        checks++; if (pc_out !== 32'd1 || ifid_npc !== 32'd1) begin errors++; $display("FAIL wrap_pc2: got pc=%h npc=%h exp 1 1", pc_out, ifid_npc); end
    endtask

    task automatic test_async_reset();
        br_taken = 1'b1; br_target = 32'd12;
        tick();
        br_taken = 1'b0; stall = 1'b1;
        tick();
        checks++; if (pc_out !== 32'd12) begin errors++; $display("FAIL areset_pre: got %h exp c", pc_out); end
        #2 rst = 1'b1;
        #1;
        checks++; if (pc_out !== 32'd0 || ifid_valid !== 1'b0 || ifid_instr !== 32'd0 || ifid_npc !== 32'd0 || halted !== 1'b0) begin errors++; $display("FAIL areset_now: got pc=%h v=%b instr=%h npc=%h h=%b exp all 0", pc_out, ifid_valid, ifid_instr, ifid_npc, halted); end
        checks++; if (fetch_cnt !== 32'd0 || stall_cnt !== 32'd0) begin errors++; $display("FAIL areset_cnt: got %h/%h exp 0/0", fetch_cnt, stall_cnt); end
        @(posedge clk);
        #1 rst = 1'b0; stall = 1'b0;
        tick();
        checks++; if (pc_out !== 32'd0 || ifid_valid !== 1'b0) begin errors++; $display("FAIL areset_boot: got pc=%h v=%b exp 0 0", pc_out, ifid_valid); end
        tick();
        checks++; if (pc_out !== 32'd1 || ifid_instr !== 32'h100 || ifid_npc !== 32'd1 || ifid_valid !== 1'b1) begin errors++; $display("FAIL areset_fetch: got pc=%h instr=%h npc=%h v=%b exp 1 100 1 1", pc_out, ifid_instr, ifid_npc, ifid_valid); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        stall     = 1'b0;
        br_taken  = 1'b0;
        br_target = 32'd0;
        halt_en   = 1'b0;
        halt_addr = 32'd0;
        test_reset();
        test_sequential();
        test_stall();
        test_branch_during_stall();
        test_halt();
        test_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_stage.md
PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first PC fetched after reset.
REQ-002 Parameter HALT_INSTR, default 32'hFFFF_FFFF, instruction word that halts fetch.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port stall  input  1  hazard unit request to hold PC and IF/ID latch.
REQ-006 Port br_taken  input  1  redirect request from a later stage.
REQ-007 Port br_target  input  32  redirect PC, word address.
REQ-008 Port pc_out  output  32  current PC; drives the external incrementer input.
REQ-009 Port pc_incr  input  32  incrementer result (pc_out+1), used as sequential next PC.
REQ-010 Port imem_addr  output  32  instruction memory address, equal to pc_out.
REQ-011 Port imem_data  input  32  combinational instruction read data for imem_addr.
REQ-012 Port ifid_instr  output  32  latched instruction to decode.
REQ-013 Port ifid_npc  output  32  latched pc_incr belonging to ifid_instr.
REQ-014 Port ifid_valid  output  1  ifid_instr is a real instruction, not a bubble.
REQ-015 Port halted  output  1  high while FSM is in HALT.
REQ-016 Port fetch_cnt  output  32  count of instructions latched valid.
REQ-017 Port stall_cnt  output  32  count of cycles with stall asserted in RUN.

Function
REQ-018 FSM states SHALL be BOOT, RUN, HALT; BOOT is the reset state.
REQ-019 BOOT SHALL last exactly one cycle, latch nothing, and go to RUN; pc_out holds RESET_PC.
REQ-020 RUN priority per edge SHALL be: br_taken > stall > halt detect > normal fetch.
REQ-021 Normal fetch: PC <= pc_incr; ifid_instr <= imem_data; ifid_npc <= pc_incr; ifid_valid <= 1.
REQ-022 br_taken (in RUN or HALT): PC <= br_target; ifid_valid <= 0; instr/npc unchanged; state RUN.
REQ-023 stall without br_taken: PC, ifid_instr, ifid_npc, ifid_valid all hold.
REQ-024 Halt detect: imem_data == HALT_INSTR in RUN, no stall/br_taken: latch it valid, PC holds, enter HALT.
REQ-025 HALT: PC holds, ifid_valid <= 0 after first HALT cycle, stall ignored; exit only by br_taken or rst.
REQ-026 Redirect latency SHALL be one cycle: pc_out == br_target in the cycle after br_taken sampled.
REQ-027 PC arithmetic SHALL be modulo 2^32; pc_incr of 32'hFFFF_FFFF yields 0, no flag.
REQ-028 imem_addr and pc_out SHALL be combinationally identical; no other output is combinational.

Reset
REQ-029 rst SHALL force immediately: state BOOT, pc_out RESET_PC, ifid_instr 0, ifid_npc 0, ifid_valid 0, halted 0, counters 0.
REQ-030 rst asserted mid-stall, mid-redirect or in HALT SHALL discard all pending work; no input is sampled while rst high.

Configuration
REQ-031 Macro FETCH_PERF_CNT_EN SHALL, when defined, build fetch_cnt (increment per valid latch) and stall_cnt (increment per RUN cycle with stall, no br_taken), both wrapping at 2^32.
REQ-032 Without FETCH_PERF_CNT_EN, fetch_cnt and stall_cnt SHALL be tied to 0 and no counter flops synthesised; port list unchanged.

Structure
REQ-033 Shared package SHALL hold the FSM state encoding (BOOT=2'd0, RUN=2'd1, HALT=2'd2), the 32-bit word type, and the default HALT_INSTR constant.
REQ-034 One sub-module, ifid_latch, SHALL hold ifid_instr/ifid_npc/ifid_valid with load, hold and bubble controls; PC register and FSM stay in the top.

Verification
REQ-035 Reset release, RESET_PC=0, imem_data=addr+32'h100 -> cycle1 pc_out 0, ifid_valid 0; then pc_out 1,2,3 and ifid_instr 32'h100,32'h101 with ifid_npc 1,2.
REQ-036 stall held 3 cycles at pc_out 5 -> pc_out stays 5, IF/ID outputs frozen; stall_cnt +3 with macro, 0 without.
REQ-037 br_taken with br_target 32'h40 while stall=1 at pc_out 7 -> next cycle pc_out 32'h40, ifid_valid 0; next cycle ifid_npc 32'h41.
REQ-038 imem_data 32'hFFFF_FFFF at pc_out 9 -> HALT latched valid, halted 1, pc_out 9 held, ifid_valid 0 next cycle; br_taken to 32'h20 resumes RUN.
REQ-039 br_target 32'hFFFF_FFFF -> pc_out sequence FFFF_FFFF, 0, 1; ifid_npc 0 for instruction at FFFF_FFFF.
REQ-040 rst pulsed mid-cycle during stall at pc_out 12 -> outputs reach reset values asynchronously; BOOT then fetch from RESET_PC.
